// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM states, frame widths and baud divisor helper for uart_tx_sched.
// Frame width depends on UART_TX_SCHED_PARITY_EN.
package uart_tx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    localparam int DATA_BITS = 8;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    function automatic int baud_count(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// uart_tx_baud_tick: bit-period counter; tick_o marks the last cycle of each period.
// clr_i holds the counter at zero so every frame starts on a fresh period.
module uart_tx_baud_tick #(
    parameter int COUNT = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = COUNT > 1 ? $clog2(COUNT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == CW'(COUNT - 1);
    assign cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte scheduler feeding an 8N1 UART transmitter.
// Define UART_TX_SCHED_PARITY_EN to append an even-parity bit (8E1 frame).
module uart_tx_sched
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx,
    output logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDW        = $clog2(NUM_REQ);
    localparam int BAUD_COUNT = baud_count(CLK_FREQ, BAUD);
`ifdef UART_TX_SCHED_PARITY_EN
    localparam state_e AFTER_DATA = PARITY;
`else
    localparam state_e AFTER_DATA = STOP;
`endif

    state_e         state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_q, bit_d;
    logic [IDW-1:0] grant_q, grant_d, last_q, last_d, sel;
    logic           armed_q, tick, xfer;

    uart_tx_baud_tick #(.COUNT(BAUD_COUNT)) u_baud (
        .clk    (clk),
        .reset_n(reset_n),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    // Scan downward so the nearest index after last_q is the one left in sel.
    always_comb begin
        sel = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req_valid[(int'(last_q) + k) % NUM_REQ]) sel = IDW'((int'(last_q) + k) % NUM_REQ);
    end

    // armed_q keeps req_ready quiet until the first edge after reset release.
    assign req_ready = (state_q == IDLE && armed_q) ? req_valid & (NUM_REQ'(1) << sel) : '0;
    assign xfer      = |req_ready;
    assign tx        = state_q == START  ? 1'b0 :
                       state_q == DATA   ? shift_q[bit_q] :
                       state_q == PARITY ? ^shift_q : 1'b1;
    assign tx_busy   = state_q != IDLE;
    assign grant_id  = grant_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (xfer) begin
                state_d = START;
                shift_d = req_data[{sel, 3'b000} +: 8];
                bit_d   = '0;
                grant_d = sel;
                last_d  = sel;
            end
            START:  if (tick) state_d = DATA;
            DATA: if (tick) begin
                bit_d   = bit_q + 1'b1;
                state_d = bit_q == 3'(DATA_BITS - 1) ? AFTER_DATA : DATA;
            end
            PARITY: if (tick) state_d = STOP;
            STOP:   if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            grant_q <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            armed_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: table-driven and randomized checks of uart_tx_sched against a frame/round-robin model.
// Frame length follows UART_TX_SCHED_PARITY_EN when the bench is built with it.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int CF = 1000;
    localparam int BD = 100;
    localparam int BC = 10;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 10 + PAR;

    typedef struct {
        logic [N-1:0]   v;
        logic [8*N-1:0] d;
        int             g;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx, tx_busy;
    logic [1:0]     grant_id;

    int   passed = 0;
    int   total = 0;
    int   mlast = N - 1;
    vec_t tbl[$];

    uart_tx_sched #(.NUM_REQ(N), .CLK_FREQ(CF), .BAUD(BD)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int rr(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic frame(input logic [N-1:0] v, input logic [8*N-1:0] d, input int eg,
                         input bit chk_gap, input bit scramble);
        int w;
        int bad;
        logic [7:0] b;
        req_valid = v;
        req_data  = d;
        w = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                w = i;
                break;
            end
        end
        if (w < 0) begin
            total++;
            $display("FAIL ready_timeout: got no req_ready expected grant %0d", eg);
            return;
        end
        if (chk_gap) check("idle_gap_cycles", w, 0);
        check("req_ready", 32'(req_ready), 32'(1) << eg);
        check("busy_in_idle", 32'(tx_busy), 0);
        b = d[eg*8 +: 8];
        mlast = eg;
        @(posedge clk);
        for (int k = 0; k < FL; k++) begin
            bad = 0;
            for (int c = 0; c < BC; c++) begin
                @(negedge clk);
                if (k == 0 && c == 0) begin
                    check("grant_id", 32'(grant_id), eg);
                    check("busy_in_frame", 32'(tx_busy), 1);
                end
                if (tx !== fbit(b, k)) bad++;
                if (scramble && k == 4 && c == 3) req_valid = N'($urandom);
            end
            check($sformatf("frame_bit%0d_badcycles", k), bad, 0);
        end
    endtask

    initial begin
        logic [N-1:0]   rv;
        logic [8*N-1:0] rd;
        int             eg;
        req_valid = 4'b1111;
        #3;
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_grant", 32'(grant_id), 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        #1 check("ready_before_edge", 32'(req_ready), 0);

        tbl.push_back('{4'b1111, 32'h44332211, 0});
        tbl.push_back('{4'b1111, 32'h8877C355, 1});
        tbl.push_back('{4'b1111, 32'h0F1E2D3C, 2});
        tbl.push_back('{4'b1111, 32'hA0B1C2D3, 3});
        tbl.push_back('{4'b1111, 32'h5A5A5A5A, 0});
        tbl.push_back('{4'b0010, 32'h00003C00, 1});
        tbl.push_back('{4'b1010, 32'h81007E00, 3});
        tbl.push_back('{4'b1010, 32'h8100E700, 1});
        tbl.push_back('{4'b0001, 32'h000000A5, 0});
        tbl.push_back('{4'b0001, 32'h000000FF, 0});
        tbl.push_back('{4'b0001, 32'h00000001, 0});
        tbl.push_back('{4'b0100, 32'h00960000, 2});
        tbl.push_back('{4'b1001, 32'h6B000012, 3});
        foreach (tbl[i]) frame(tbl[i].v, tbl[i].d, tbl[i].g, i > 0, 1'b0);

        req_valid = 4'b0001;
        req_data  = 32'h0000003C;
        for (int i = 0; i < 40 && req_ready == '0; i++) @(negedge clk);
        @(posedge clk);
        repeat (45) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midframe_rst_tx", 32'(tx), 1);
        check("midframe_rst_busy", 32'(tx_busy), 0);
        check("midframe_rst_ready", 32'(req_ready), 0);
        @(negedge clk);
        check("rst_held_ready", 32'(req_ready), 0);
        #2 reset_n = 1'b1;
        #1 check("release_ready", 32'(req_ready), 0);
        mlast = N - 1;
        frame(4'b0001, 32'h000000C6, 0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rv = N'($urandom_range(1, (1 << N) - 1));
            rd = $urandom;
            eg = rr(rv, mlast);
            frame(rv, rd, eg, 1'b1, 1'b1);
        end

        req_valid = '0;
        @(negedge clk);
        check("final_idle_busy", 32'(tx_busy), 0);
        check("final_idle_tx", 32'(tx), 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of byte requesters (2..8).
REQ-002 SHALL have parameter CLK_FREQ, default 100_000_000, meaning system clock frequency in Hz.
REQ-003 SHALL have parameter BAUD, default 9600, meaning line bit rate in bit/s.
REQ-004 SHALL have port clk, input, 1 bit: single system clock, rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: requester i holds a byte.
REQ-007 SHALL have port req_data, input, NUM_REQ*8 bits: byte i at bits [8i+7:8i].
REQ-008 SHALL have port req_ready, output, NUM_REQ bits: one-hot accept strobe.
REQ-009 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port tx_busy, output, 1 bit: high while a frame is on the line.
REQ-011 SHALL have port grant_id, output, $clog2(NUM_REQ) bits: index of the last accepted requester.

Function
REQ-012 SHALL define BAUD_COUNT = CLK_FREQ/BAUD (integer division); each bit period SHALL be exactly BAUD_COUNT clk cycles.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE with any req_valid set, SHALL select the first set index at or after (last_grant+1) mod NUM_REQ.
REQ-015 SHALL drive req_ready combinationally, only in IDLE and only for the selected index; transfer occurs on valid&ready in that cycle.
REQ-016 SHALL capture the byte into the shift register on transfer, update grant_id and last_grant, and enter START on the next edge.
REQ-017 SHALL clear the baud counter on entry to START; a baud tick is asserted when the counter equals BAUD_COUNT-1, then the counter wraps to 0.
REQ-018 SHALL drive tx=0 in START, tx=data bit LSB-first in DATA (8 ticks, 3-bit index), and tx=1 in STOP (one bit period).
REQ-019 On the STOP tick, SHALL return to IDLE; the minimum gap between back-to-back frames is 1 clk of IDLE.
REQ-020 tx_busy SHALL be 1 in every state except IDLE.
REQ-021 SHALL ignore req_valid changes and deassertions outside IDLE; a requester deasserting valid before grant loses no frame.
REQ-022 With a single requester continuously valid, SHALL grant it on every frame (no starvation penalty).

Reset
REQ-023 On reset_n low, SHALL asynchronously force: state=IDLE, tx=1, tx_busy=0, req_ready=0, grant_id=0, last_grant=NUM_REQ-1, baud counter=0, shift register=0.
REQ-024 Reset mid-frame SHALL abort the frame; tx SHALL be 1 immediately, and no req_ready SHALL be issued until the first clk edge after release.

Configuration
REQ-025 With UART_TX_SCHED_PARITY_EN defined, SHALL insert a PARITY state between DATA and STOP, driving even parity (XOR of the 8 data bits) for one bit period (11-bit frame).
REQ-026 Without UART_TX_SCHED_PARITY_EN, the PARITY state SHALL be unreachable and DATA SHALL go directly to STOP (10-bit frame).

Structure
REQ-027 SHALL place the FSM state enum, the frame width constants, and the BAUD_COUNT computation function in package uart_tx_pkg.
REQ-028 SHALL instantiate one sub-module, uart_tx_baud_tick (counter with synchronous clear input, tick output, active-low asynchronous reset); arbitration and FSM stay in the top.

Verification (CLK_FREQ=1000, BAUD=100, giving BAUD_COUNT=10, NUM_REQ=4)
REQ-029 SHALL cover: req_valid=0001, data0=0xA5 -> req_ready=0001 for 1 cycle; tx waveform 0,1,0,1,0,0,1,0,1,1 with each bit 10 clk; frame length 100 clk (110 with parity, parity bit=0).
REQ-030 SHALL cover: req_valid=1111 held -> grant order 0,1,2,3,0; grant_id matches each req_ready pulse.
REQ-031 SHALL cover: req_valid=1010 after grant 1 -> next grant 3, then 1.
REQ-032 SHALL cover: reset_n low at clk 45 of a frame -> tx=1, tx_busy=0 asynchronously; after release, a pending request starts a fresh frame with a full 10-clk start bit.
REQ-033 SHALL cover: back-to-back frames with valid held -> exactly 1 IDLE clk between STOP end and the next start bit.
REQ-034 SHALL cover: data0=0xFF with parity enabled -> parity bit=0; data0=0x01 -> parity bit=1.
